nibble_serial_add_ctrl: RTL



---
 rtl/nibble_serial_add_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit add/sub sequenced through one shared 4-bit adder slice.
// Operands latch on an in_valid/in_ready handshake; the result is held until out_valid/out_ready.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW+1:0]  base;

  // Bit offset of the current nibble; sized so idx*4 cannot wrap.
  assign base = {idx_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so B is stored pre-inverted.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy                = 1'b1;
        slice_a             = a_q[base +: 4];
        slice_b             = b_q[base +: 4];
        slice_cin           = carry_q;
        sum_d[base +: 4]    = slice_s;
        carry_d             = slice_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
